// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter:
// the FSM state encoding and the master index constants.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational tie-break for the 2:1 Wishbone arbiter.
// WB_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise master 1 always wins a tie.
module wb_arb_pick
  import wb_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic win
);

`ifdef WB_ARB_ROUND_ROBIN_EN
  // On a tie the master that did not own the bus most recently goes next.
  always_comb begin
    win = M0;
    if (req0 && req1) begin
      win = ~last_grant;
    end else if (req1) begin
      win = M1;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Master 1 (data bus) has fixed priority on a tie.
  always_comb begin
    win = M0;
    if (req1) begin
      win = M1;
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Two-master to one-slave Wishbone arbiter: registered grant FSM, output muxes.
// Optional macro WB_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking.
module wb_arbiter_2to1
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,

  input  logic [ADDR_WIDTH-1:0]     m0_adr_i,
  input  logic [DATA_WIDTH-1:0]     m0_dat_i,
  input  logic                      m0_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_cyc_i,
  output logic [DATA_WIDTH-1:0]     m0_dat_o,
  output logic                      m0_ack_o,

  input  logic [ADDR_WIDTH-1:0]     m1_adr_i,
  input  logic [DATA_WIDTH-1:0]     m1_dat_i,
  input  logic                      m1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_cyc_i,
  output logic [DATA_WIDTH-1:0]     m1_dat_o,
  output logic                      m1_ack_o,

  output logic [ADDR_WIDTH-1:0]     s_adr_o,
  output logic [DATA_WIDTH-1:0]     s_dat_o,
  output logic                      s_we_o,
  output logic [DATA_WIDTH/8-1:0]   s_sel_o,
  output logic                      s_stb_o,
  output logic                      s_cyc_o,
  input  logic [DATA_WIDTH-1:0]     s_dat_i,
  input  logic                      s_ack_i
);

  arb_state_t state, state_nxt;
  logic       req0, req1;
  logic       win;
  logic       last_grant;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  wb_arb_pick u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant),
    .win        (win)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Reset value M1 lets master 0 take the first tie.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      last_grant <= M1;
    end else if ((state == IDLE) && (req0 || req1)) begin
      last_grant <= win;
    end
  end
`else
  assign last_grant = M1;
`endif

  // Ownership is released only when the owner drops cyc, so bursts are never split.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = (win == M1) ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Self-checking bench for wb_arbiter_2to1: ownership model, simple slave responder,
// directed scenarios; honours WB_ARB_ROUND_ROBIN_EN for the tie expectations.
module tb_wb_arbiter_2to1;

  logic        clk;
  logic        rst;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic        m_we  [2];
  logic [3:0]  m_sel [2];
  logic        m_stb [2];
  logic        m_cyc [2];
  logic [31:0] dat_o [2];
  logic        ack_o [2];
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [3:0]  s_sel;
  logic        ack_r, ack_force;

  int checks = 0;
  int errors = 0;

  wb_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_adr_i (m_adr[0]), .m0_dat_i (m_dat[0]), .m0_we_i (m_we[0]),
    .m0_sel_i (m_sel[0]), .m0_stb_i (m_stb[0]), .m0_cyc_i (m_cyc[0]),
    .m0_dat_o (dat_o[0]), .m0_ack_o (ack_o[0]),
    .m1_adr_i (m_adr[1]), .m1_dat_i (m_dat[1]), .m1_we_i (m_we[1]),
    .m1_sel_i (m_sel[1]), .m1_stb_i (m_stb[1]), .m1_cyc_i (m_cyc[1]),
    .m1_dat_o (dat_o[1]), .m1_ack_o (ack_o[1]),
    .s_adr_o  (s_adr), .s_dat_o (s_dat_o), .s_we_o (s_we),
    .s_sel_o  (s_sel), .s_stb_o (s_stb), .s_cyc_o (s_cyc),
    .s_dat_i  (s_dat_i), .s_ack_i (s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: acks one cycle after it sees a strobe; logs every completed beat.
  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];
  logic        log_we  [$];
  int          ack_q   [$];

  assign s_ack = ack_r | ack_force;

  always @(posedge clk) begin
    if (s_stb && s_cyc && s_ack) begin
      log_adr.push_back(s_adr);
      log_dat.push_back(s_dat_o);
      log_we.push_back(s_we);
    end
    ack_r   <= s_stb && s_cyc && !ack_r;
    s_dat_i <= (s_adr == 32'h100) ? 32'hDEADBEEF : ~s_adr;
  end

  // Ownership model: -1 = bus free, otherwise index of the owning master.
  int owner = -1;
  int last  = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owner = -1;
      last  = 1;
    end else if (owner < 0) begin
      if (m_cyc[0] && m_stb[0] && m_cyc[1] && m_stb[1]) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        owner = (last == 0) ? 1 : 0;
`else
        owner = 1;
`endif
      end else if (m_cyc[0] && m_stb[0]) begin
        owner = 0;
      end else if (m_cyc[1] && m_stb[1]) begin
        owner = 1;
      end
      if (owner >= 0) last = owner;
    end else if (!m_cyc[owner]) begin
      owner = -1;
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic [70:0] exp_s;
    exp_s = '0;
    if (owner >= 0)
      exp_s = {m_adr[owner], m_dat[owner], m_we[owner], m_sel[owner], m_stb[owner], m_cyc[owner]};
    chk("slave_req", {57'd0, s_adr, s_dat_o, s_we, s_sel, s_stb, s_cyc}, {57'd0, exp_s});
    chk("m0_ack", {127'd0, ack_o[0]}, {127'd0, (owner == 0) && s_ack});
    chk("m1_ack", {127'd0, ack_o[1]}, {127'd0, (owner == 1) && s_ack});
    for (int i = 0; i < 2; i++) begin
      if (ack_o[i]) begin
        chk("dat_o", {96'd0, dat_o[i]}, {96'd0, s_dat_i});
        ack_q.push_back(i);
      end
    end
  end

  task automatic wait_ack(input int idx);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_o[idx] && n < 80);
    if (!ack_o[idx]) begin
      errors++;
      $display("FAIL ack_timeout master=%0d actual=0 required=1", idx);
    end
  endtask

  // Master: ntxn cycles of 'beats' back-to-back beats, idle 'gap' edges between cycles.
  task automatic master_run(input int idx, input int ntxn, input int beats,
                            input logic [31:0] base, input logic we, input int gap);
    for (int t = 0; t < ntxn; t++) begin
      m_cyc[idx] = 1'b1;
      for (int b = 0; b < beats; b++) begin
        m_stb[idx] = 1'b1;
        m_adr[idx] = base + 32'(4 * (t * beats + b));
        m_dat[idx] = 32'hC0DE0000 + 32'(t * beats + b);
        m_we[idx]  = we;
        m_sel[idx] = 4'hF;
        wait_ack(idx);
        @(posedge clk); #1;
      end
      m_cyc[idx] = 1'b0;
      m_stb[idx] = 1'b0;
      m_we[idx]  = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    log_adr.delete(); log_dat.delete(); log_we.delete(); ack_q.delete();
  endtask

  task automatic check_order(input string name, input int exp0, input int exp1,
                             input int exp2, input int exp3);
    int e [4];
    e = '{exp0, exp1, exp2, exp3};
    chk({name, "_len"}, 128'(ack_q.size()), 128'd4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++)
      chk(name, 128'(ack_q[i]), 128'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ack_r = 1'b0;
    ack_force = 1'b0;
    s_dat_i = '0;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_we[i] = 1'b0;
      m_sel[i] = '0; m_stb[i] = 1'b0; m_cyc[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stb", {127'd0, s_stb}, 128'd0);
    chk("rst_cyc", {127'd0, s_cyc}, 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single read by m0: no combinational grant, one-cycle latency, data returned.
    clear_logs();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h100; m_we[0] = 1'b0; m_sel[0] = 4'hF;
    @(negedge clk);
    chk("stb_not_comb", {127'd0, s_stb}, 128'd0);
    @(negedge clk);
    chk("grant_latency", {127'd0, s_stb}, 128'd1);
    chk("grant_adr", {96'd0, s_adr}, 128'h100);
    wait_ack(0);
    chk("read_ack", {127'd0, ack_o[0]}, 128'd1);
    chk("read_data", {96'd0, dat_o[0]}, 128'hDEADBEEF);
    chk("read_m1_ack", {127'd0, ack_o[1]}, 128'd0);
    @(posedge clk); #1;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Tie from reset: both masters do two single-beat cycles, one idle edge apart.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    fork
      master_run(0, 2, 1, 32'h1000, 1'b0, 1);
      master_run(1, 2, 1, 32'h2000, 1'b0, 1);
    join
    repeat (3) @(posedge clk); #1;
`ifdef WB_ARB_ROUND_ROBIN_EN
    check_order("tie_order", 0, 1, 0, 1);
`else
    check_order("tie_order", 1, 1, 0, 0);
`endif

    // Burst hold: m1 writes four words while m0 is waiting.
    clear_logs();
    fork
      master_run(1, 1, 4, 32'h200, 1'b1, 1);
      begin
        @(posedge clk); #1;
        master_run(0, 1, 1, 32'h100, 1'b0, 1);
      end
    join
    repeat (3) @(posedge clk); #1;
    chk("burst_len", 128'(log_adr.size()), 128'd5);
    if (log_adr.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        chk("burst_adr", {96'd0, log_adr[i]}, 128'(32'h200 + 32'(4 * i)));
        chk("burst_dat", {96'd0, log_dat[i]}, 128'(32'hC0DE0000 + 32'(i)));
        chk("burst_we", {127'd0, log_we[i]}, 128'd1);
      end
      chk("burst_m0_after", {96'd0, log_adr[4]}, 128'h100);
      chk("burst_m0_read", {127'd0, log_we[4]}, 128'd0);
    end

    // Reset while m0 owns the bus with its ack still outstanding.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h300; m_we[0] = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!s_stb && n < 10);
      chk("mid_rst_granted", {127'd0, s_stb}, 128'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stb", {127'd0, s_stb}, 128'd0);
    chk("mid_rst_cyc", {127'd0, s_cyc}, 128'd0);
    ack_force = 1'b1;
    #1;
    chk("mid_rst_late_ack", {127'd0, ack_o[0]}, 128'd0);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_late_ack", {127'd0, ack_o[0]}, 128'd0);
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(posedge clk); #1;

    // First arbitration after reset release.
    clear_logs();
    master_run(0, 1, 1, 32'h100, 1'b0, 1);
    chk("post_rst_txn", 128'(log_adr.size()), 128'd1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
